// File: rtl/uart_tx_stim.sv
// ============================================================================
//  Module   : uart_tx_stim
//  Brief    : 8N1 UART transmitter with a small byte FIFO in front of it.
//             Drives serial stimulus into a UART RX pad from a valid/ready
//             byte source. LSB first, one start bit, one stop bit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_stim #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNTW-1:0] C_FULL_CNT  = CNTW'(FIFO_DEPTH);
  localparam logic [CW-1:0]   C_BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   C_BAUD_PRE  = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic [CNTW-1:0] count_d;

  // Transmit engine state
  state_t          state_q;
  logic [CW-1:0]   baud_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            busy_q;
  logic            frame_done_q;

  logic            w_push;
  logic            w_pop;
  logic            w_bit_end;
  logic [7:0]      w_head;

  // Ready looks only at the registered occupancy, so a full FIFO refuses
  // a push even in the cycle it is popping.
  assign tx_ready  = (count_q < C_FULL_CNT);
  assign w_push    = tx_valid && tx_ready;
  assign w_bit_end = (baud_q == C_BAUD_LAST);
  assign w_pop     = (count_q != '0) &&
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && w_bit_end));
  assign w_head    = mem_q[rd_ptr_q];

  // Occupancy next value: +1 push only, -1 pop only, unchanged otherwise
  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO data array; contents need no reset since occupancy guards reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-2 depth)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  // Frame sequencer: IDLE -> START -> DATA x8 -> STOP, with all line-facing
  // outputs registered. STOP chains straight into START when data waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (w_pop) begin
            shift_q <= w_head;
            state_q <= ST_START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= ST_DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            baud_q <= '0;
            if (w_pop) begin
              shift_q <= w_head;
              state_q <= ST_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q       <= baud_q + CW'(1);
            // Raise the pulse as the counter enters the last stop cycle
            frame_done_q <= (baud_q == C_BAUD_PRE);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign fifo_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_stim.sv
// ============================================================================
//  Module   : tb_uart_tx_stim
//  Brief    : Directed self-checking bench for uart_tx_stim
//             (CLKS_PER_BIT=4, FIFO_DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_stim;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  int         fd_count   = 0;
  int         rst_edges  = 0;
  logic [7:0] mon_byte;
  int         mon_rst0;
  int         mon_bad;

  uart_tx_stim #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_count <= fd_count + 1;
    if (rst === 1'b1)        rst_edges <= rst_edges + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Receiver model: samples mid-bit, drops frames disturbed by reset
  always begin
    @(posedge clk);
    #1;
    if (rst === 1'b0 && tx === 1'b0) begin
      mon_rst0 = rst_edges;
      mon_bad  = 0;
      mon_wait(2);
      if (tx !== 1'b0) mon_bad = 1;
      for (int i = 0; i < 8; i++) begin
        mon_wait(4);
        mon_byte[i] = tx;
      end
      mon_wait(4);
      if (tx !== 1'b1) mon_bad = 1;
      mon_wait(1);
      if (rst_edges == mon_rst0 && mon_bad == 0) rx_q.push_back(mon_byte);
    end
  end

  // Expected line level at position p (0..39) of a frame carrying b
  function automatic logic exp_bit(input logic [7:0] b, input int p);
    if (p < 4)       return 1'b0;
    else if (p < 36) return b[(p - 4) / 4];
    else             return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) tick();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || tx_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values tx=%b busy=%b cnt=%0d rdy=%b fd=%b (required 1 0 0 1 0)",
               tx, busy, fifo_count, tx_ready, frame_done);
    end
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d tx=%b busy=%b cnt=%0d rdy=%b (required 1 0 0 1)",
                 c, tx, busy, fifo_count, tx_ready);
      end
    end
  endtask

  task automatic test_single();
    int fd0;
    rx_q.delete();
    fd0 = fd_count;
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd1 || tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_push cnt=%0d tx=%b busy=%b (required 1 1 0)", fifo_count, tx, busy);
    end
    for (int j = 1; j <= 40; j++) begin
      tick();
      checks++;
      if (tx !== exp_bit(8'h55, j - 1) || busy !== 1'b1 || frame_done !== (j == 40)) begin
        errors++;
        $display("FAIL single_frame j=%0d tx=%b busy=%b fd=%b (required %b 1 %b)",
                 j, tx, busy, frame_done, exp_bit(8'h55, j - 1), (j == 40));
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL single_end busy=%b tx=%b cnt=%0d (required 0 1 0)", busy, tx, fifo_count);
    end
    repeat (3) tick();
    checks++;
    if (rx_q.size() != 1 || fd_count - fd0 != 1) begin
      errors++;
      $display("FAIL single_rx bytes=%0d pulses=%0d (required 1 1)", rx_q.size(), fd_count - fd0);
    end else begin
      checks++;
      if (rx_q[0] !== 8'h55) begin
        errors++;
        $display("FAIL single_rx_data got=%h required=55", rx_q[0]);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] b[5];
    logic [2:0] cnt_exp[5];
    b       = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    cnt_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      tx_data = b[i]; tx_valid = 1'b1;
      checks++;
      if (tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL burst_ready_pre i=%0d rdy=%b required=1", i, tx_ready);
      end
      tick();
      checks++;
      if (fifo_count !== cnt_exp[i] || (i > 0 && tx !== 1'b0)) begin
        errors++;
        $display("FAIL burst_push i=%0d cnt=%0d tx=%b (required %0d %b)",
                 i, fifo_count, tx, cnt_exp[i], (i > 0) ? 1'b0 : 1'b1);
      end
    end
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL burst_full rdy=%b required=0", tx_ready);
    end
    for (int j = 5; j <= 200; j++) begin
      tick();
      checks++;
      if (tx !== exp_bit(b[(j - 1) / 40], (j - 1) % 40) || busy !== 1'b1) begin
        errors++;
        $display("FAIL burst_line j=%0d tx=%b busy=%b (required %b 1)",
                 j, tx, busy, exp_bit(b[(j - 1) / 40], (j - 1) % 40));
      end
      if (j == 41) begin
        checks++;
        if (fifo_count !== 3'd3 || tx_ready !== 1'b1) begin
          errors++;
          $display("FAIL burst_slot cnt=%0d rdy=%b (required 3 1)", fifo_count, tx_ready);
        end
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL burst_end busy=%b tx=%b cnt=%0d (required 0 1 0)", busy, tx, fifo_count);
    end
    repeat (3) tick();
    checks++;
    if (rx_q.size() != 5) begin
      errors++;
      $display("FAIL burst_rx_count got=%0d required=5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_q[i] !== b[i]) begin
          errors++;
          $display("FAIL burst_rx_data i=%0d got=%h required=%h", i, rx_q[i], b[i]);
        end
      end
    end
  endtask

  task automatic test_simul();
    logic [7:0] s[4];
    s = '{8'h12, 8'hC3, 8'h5A, 8'h7E};
    rx_q.delete();
    for (int i = 0; i < 3; i++) begin
      tx_data = s[i]; tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    for (int j = 3; j <= 40; j++) tick();
    checks++;
    if (fifo_count !== 3'd2 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL simul_pre cnt=%0d fd=%b (required 2 1)", fifo_count, frame_done);
    end
    tx_data = s[3]; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd2 || tx !== 1'b0) begin
      errors++;
      $display("FAIL simul_push_pop cnt=%0d tx=%b (required 2 0)", fifo_count, tx);
    end
    for (int j = 42; j <= 160; j++) begin
      tick();
      checks++;
      if (tx !== exp_bit(s[(j - 1) / 40], (j - 1) % 40)) begin
        errors++;
        $display("FAIL simul_line j=%0d tx=%b required=%b", j, tx, exp_bit(s[(j - 1) / 40], (j - 1) % 40));
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL simul_end busy=%b cnt=%0d (required 0 0)", busy, fifo_count);
    end
    repeat (3) tick();
    checks++;
    if (rx_q.size() != 4) begin
      errors++;
      $display("FAIL simul_rx_count got=%0d required=4", rx_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_q[i] !== s[i]) begin
          errors++;
          $display("FAIL simul_rx_data i=%0d got=%h required=%h", i, rx_q[i], s[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] m[3];
    int fd0;
    m = '{8'hF0, 8'h11, 8'h22};
    rx_q.delete();
    fd0 = fd_count;
    for (int i = 0; i < 3; i++) begin
      tx_data = m[i]; tx_valid = 1'b1;
      tick();
    end
    tx_valid = 1'b0;
    for (int j = 3; j <= 18; j++) tick();
    checks++;
    if (fifo_count !== 3'd2 || tx !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pre cnt=%0d tx=%b (required 2 0)", fifo_count, tx);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || frame_done !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_edge tx=%b cnt=%0d busy=%b fd=%b rdy=%b (required 1 0 0 0 1)",
               tx, fifo_count, busy, frame_done, tx_ready);
    end
    for (int c = 0; c < 60; c++) begin
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || fifo_count !== 3'd0) begin
        errors++;
        $display("FAIL rstmid_idle c=%0d tx=%b busy=%b fd=%b cnt=%0d (required 1 0 0 0)",
                 c, tx, busy, frame_done, fifo_count);
      end
    end
    checks++;
    if (fd_count != fd0 || rx_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_nopulse pulses=%0d bytes=%0d (required 0 0)", fd_count - fd0, rx_q.size());
    end
  endtask

  task automatic test_hold_valid();
    logic [7:0] e[7];
    int n;
    e = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h6A, 8'h92};
    rx_q.delete();
    for (int i = 0; i < 100; i++) begin
      tx_data  = 8'h40 + 8'(i);
      tx_valid = 1'b1;
      tick();
      checks++;
      if (tx_ready !== (i < 4 || i == 41 || i == 81)) begin
        errors++;
        $display("FAIL hold_ready i=%0d rdy=%b required=%b", i, tx_ready, (i < 4 || i == 41 || i == 81));
      end
    end
    tx_valid = 1'b0;
    n = 0;
    while ((busy !== 1'b0 || fifo_count !== 3'd0) && n < 600) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 600) begin
      errors++;
      $display("FAIL hold_drain_timeout busy=%b cnt=%0d (required 0 0)", busy, fifo_count);
    end
    repeat (3) tick();
    checks++;
    if (rx_q.size() != 7) begin
      errors++;
      $display("FAIL hold_rx_count got=%0d required=7", rx_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (rx_q[i] !== e[i]) begin
          errors++;
          $display("FAIL hold_rx_data i=%0d got=%h required=%h", i, rx_q[i], e[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_simul();
    test_reset_mid();
    test_hold_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
